// File: rtl/fifo_ptr_ctrl.sv
// ============================================================================
// fifo_ptr_ctrl : pointer, occupancy and flag controller for a FIFO memory.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module fifo_ptr_ctrl #(
  parameter int DATA_WIDTH      = 32,
  parameter int OSTD_NUM        = 8,
  parameter int THRESHOLD_VALUE = OSTD_NUM / 2,
  parameter int PTR_SIZE        = $clog2(OSTD_NUM)
) (
  input  logic                  clk_in,
  input  logic                  areset_b,
  input  logic                  wr_req,
  input  logic                  rd_req,
  input  logic                  err_clr,
  output logic                  fifo_wenable,
  output logic                  fifo_renable,
  output logic [OSTD_NUM-1:0]   write_ptr,
  output logic [OSTD_NUM-1:0]   read_ptr,
  output logic [PTR_SIZE:0]     fifo_count,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  below_thresh,
  output logic                  overflow_err,
  output logic                  underflow_err
);

  localparam logic [PTR_SIZE-1:0] c_ptr_last = PTR_SIZE'(OSTD_NUM - 1);
  localparam logic [PTR_SIZE:0]   c_cnt_full = (PTR_SIZE + 1)'(OSTD_NUM);
  localparam logic [PTR_SIZE:0]   c_cnt_thr  = (PTR_SIZE + 1)'(THRESHOLD_VALUE);

  generate
    if (DATA_WIDTH < 1 || OSTD_NUM < 2 ||
        THRESHOLD_VALUE < 1 || THRESHOLD_VALUE > OSTD_NUM) begin : g_bad_params
      $error("fifo_ptr_ctrl: illegal parameter combination");
    end
  endgenerate

  logic [PTR_SIZE-1:0] wptr_q, wptr_d;
  logic [PTR_SIZE-1:0] rptr_q, rptr_d;
  logic [PTR_SIZE:0]   count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                w_wen;
  logic                w_ren;

  assign fifo_full    = (count_q == c_cnt_full);
  assign fifo_empty   = (count_q == '0);
  assign below_thresh = (count_q < c_cnt_thr);

  assign w_wen        = wr_req & ~fifo_full;
  assign w_ren        = rd_req & ~fifo_empty;
  assign fifo_wenable = w_wen;
  assign fifo_renable = w_ren;

  // Depth need not be a power of two, so wrap explicitly at the last index.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (w_wen) begin
      wptr_d = (wptr_q == c_ptr_last) ? '0 : wptr_q + 1'b1;
    end
    if (w_ren) begin
      rptr_d = (rptr_q == c_ptr_last) ? '0 : rptr_q + 1'b1;
    end
    case ({w_wen, w_ren})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // A new error event on the same edge as err_clr keeps the flag set.
  always_comb begin
    ovf_d = (wr_req & fifo_full)  | (ovf_q & ~err_clr);
    unf_d = (rd_req & fifo_empty) | (unf_q & ~err_clr);
  end

  always_ff @(posedge clk_in) begin
    if (!areset_b) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign write_ptr     = {{(OSTD_NUM - PTR_SIZE){1'b0}}, wptr_q};
  assign read_ptr      = {{(OSTD_NUM - PTR_SIZE){1'b0}}, rptr_q};
  assign fifo_count    = count_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_ptr_ctrl.sv
// ============================================================================
// tb_fifo_ptr_ctrl : directed bench with an occupancy model for fifo_ptr_ctrl.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_ptr_ctrl;

  localparam int N   = 8;
  localparam int THR = 4;
  localparam int PS  = $clog2(N);

  logic          clk_in = 1'b0;
  logic          areset_b = 1'b0;
  logic          wr_req = 1'b0;
  logic          rd_req = 1'b0;
  logic          err_clr = 1'b0;
  logic          fifo_wenable;
  logic          fifo_renable;
  logic [N-1:0]  write_ptr;
  logic [N-1:0]  read_ptr;
  logic [PS:0]   fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          below_thresh;
  logic          overflow_err;
  logic          underflow_err;

  fifo_ptr_ctrl #(
    .DATA_WIDTH      (32),
    .OSTD_NUM        (N),
    .THRESHOLD_VALUE (THR)
  ) dut (
    .clk_in        (clk_in),
    .areset_b      (areset_b),
    .wr_req        (wr_req),
    .rd_req        (rd_req),
    .err_clr       (err_clr),
    .fifo_wenable  (fifo_wenable),
    .fifo_renable  (fifo_renable),
    .write_ptr     (write_ptr),
    .read_ptr      (read_ptr),
    .fifo_count    (fifo_count),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .below_thresh  (below_thresh),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  int m_cnt = 0;
  int m_wp  = 0;
  int m_rp  = 0;
  int m_ovf = 0;
  int m_unf = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Occupancy model: pointers are plain indices modulo depth.
  always @(posedge clk_in) begin
    int acc_w, acc_r;
    acc_w = (wr_req && m_cnt != N) ? 1 : 0;
    acc_r = (rd_req && m_cnt != 0) ? 1 : 0;
    if (!areset_b) begin
      m_cnt = 0; m_wp = 0; m_rp = 0; m_ovf = 0; m_unf = 0;
    end else begin
      if (wr_req && m_cnt == N) m_ovf = 1; else if (err_clr) m_ovf = 0;
      if (rd_req && m_cnt == 0) m_unf = 1; else if (err_clr) m_unf = 0;
      m_wp  = (m_wp + acc_w) % N;
      m_rp  = (m_rp + acc_r) % N;
      m_cnt = m_cnt + acc_w - acc_r;
    end
  end

  always @(negedge clk_in) begin
    if (chk_en) begin
      chk("wenable",   32'(fifo_wenable),  32'((wr_req && m_cnt != N) ? 1 : 0));
      chk("renable",   32'(fifo_renable),  32'((rd_req && m_cnt != 0) ? 1 : 0));
      chk("write_ptr", 32'(write_ptr),     32'(m_wp));
      chk("read_ptr",  32'(read_ptr),      32'(m_rp));
      chk("count",     32'(fifo_count),    32'(m_cnt));
      chk("full",      32'(fifo_full),     32'(m_cnt == N ? 1 : 0));
      chk("empty",     32'(fifo_empty),    32'(m_cnt == 0 ? 1 : 0));
      chk("below",     32'(below_thresh),  32'(m_cnt < THR ? 1 : 0));
      chk("overflow",  32'(overflow_err),  32'(m_ovf));
      chk("underflow", 32'(underflow_err), 32'(m_unf));
      chk("invariant", 32'(m_cnt % N),     32'((m_wp - m_rp + N) % N));
    end
  end

  task automatic cyc(input logic wr, input logic rd, input logic clr, input logic rstb);
    wr_req   = wr;
    rd_req   = rd;
    err_clr  = clr;
    areset_b = rstb;
    @(negedge clk_in);
    #1;
  endtask

  initial begin
    @(negedge clk_in);
    #1;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk_en = 1'b1;
    repeat (3) cyc(0, 0, 0, 1);
    chk("pin_rst_count", 32'(fifo_count), 32'd0);
    chk("pin_rst_empty", 32'(fifo_empty), 32'd1);
    chk("pin_rst_below", 32'(below_thresh), 32'd1);
    chk("pin_rst_wptr",  32'(write_ptr), 32'd0);

    repeat (8) cyc(1, 0, 0, 1);
    chk("pin_fill_count", 32'(fifo_count), 32'd8);
    chk("pin_fill_full",  32'(fifo_full), 32'd1);
    chk("pin_fill_wptr",  32'(write_ptr), 32'd0);
    chk("pin_fill_below", 32'(below_thresh), 32'd0);

    cyc(1, 0, 0, 1);
    chk("pin_ovf_set",   32'(overflow_err), 32'd1);
    chk("pin_ovf_count", 32'(fifo_count), 32'd8);
    cyc(0, 0, 1, 1);
    chk("pin_ovf_clr",   32'(overflow_err), 32'd0);

    cyc(1, 1, 0, 1);
    chk("pin_both_rptr",  32'(read_ptr), 32'd1);
    chk("pin_both_count", 32'(fifo_count), 32'd7);
    chk("pin_both_full",  32'(fifo_full), 32'd0);

    repeat (7) cyc(0, 1, 0, 1);
    chk("pin_drain_empty", 32'(fifo_empty), 32'd1);
    cyc(0, 1, 0, 1);
    chk("pin_unf_set", 32'(underflow_err), 32'd1);
    cyc(1, 1, 0, 1);
    chk("pin_empty_both_count", 32'(fifo_count), 32'd1);
    chk("pin_empty_both_rptr",  32'(read_ptr), 32'd0);

    cyc(0, 1, 1, 1);
    chk("pin_unf_clr", 32'(underflow_err), 32'd0);
    repeat (5) cyc(1, 0, 0, 1);
    repeat (20) cyc(1, 1, 0, 1);
    chk("pin_stream_count", 32'(fifo_count), 32'd5);
    chk("pin_stream_wptr",  32'(write_ptr), 32'd2);
    chk("pin_stream_rptr",  32'(read_ptr), 32'd5);

    cyc(0, 0, 0, 0);
    repeat (6) cyc(1, 0, 0, 1);
    chk("pin_pre_rst_count", 32'(fifo_count), 32'd6);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("pin_mid_rst_count", 32'(fifo_count), 32'd0);
    chk("pin_mid_rst_wptr",  32'(write_ptr), 32'd0);
    chk("pin_mid_rst_empty", 32'(fifo_empty), 32'd1);

    cyc(0, 0, 0, 1);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_ptr_ctrl.md
Name: fifo_ptr_ctrl

Overview:
Pointer and flag controller for the FIFO memory storage. It sits directly upstream of the memory array and drives its read/write enables and read/write pointers. It accepts producer write requests and consumer read requests, gates them against full and empty, and tracks occupancy. It also raises threshold flags and sticky overflow/underflow error flags.

Parameters:
- DATA_WIDTH, 32: transaction data width. Used only for documentation and consistency with the memory array; no logic depends on it.
- OSTD_NUM, 8: FIFO depth (number of outstanding entries), ≥ 2. Any integer is legal; a power of 2 is not required.
- THRESHOLD_VALUE, OSTD_NUM/2: occupancy boundary for below_thresh; legal range 1..OSTD_NUM.
- PTR_SIZE, $clog2(OSTD_NUM): internal pointer width. The count register is PTR_SIZE+1 bits.

Ports:
- clk_in, input, 1: clock; all logic is on its rising edge.
- areset_b, input, 1: reset, synchronous, active-low.
- wr_req, input, 1: producer write request.
- rd_req, input, 1: consumer read request.
- err_clr, input, 1: clears the sticky error flags.
- fifo_wenable, output, 1: write enable to the memory array.
- fifo_renable, output, 1: read enable to the memory array.
- write_ptr, output, OSTD_NUM: binary write index. Upper bits above PTR_SIZE are always 0.
- read_ptr, output, OSTD_NUM: binary read index. Upper bits above PTR_SIZE are always 0.
- fifo_count, output, PTR_SIZE+1: current occupancy, 0..OSTD_NUM.
- fifo_full, output, 1: high when fifo_count == OSTD_NUM.
- fifo_empty, output, 1: high when fifo_count == 0.
- below_thresh, output, 1: high when fifo_count < THRESHOLD_VALUE.
- overflow_err, output, 1: sticky; set by a write attempt while full.
- underflow_err, output, 1: sticky; set by a read attempt while empty.

Behaviour:
- Reset (areset_b sampled low at a clk_in edge):
  - write_ptr = 0, read_ptr = 0, fifo_count = 0.
  - overflow_err = 0, underflow_err = 0.
  - Consequently fifo_empty = 1, fifo_full = 0, below_thresh = 1.
- Reset asserted mid-operation discards all occupancy on that edge. Memory contents are not cleared by this block.
- Enables are combinational from the current state:
  - fifo_wenable = wr_req & ~fifo_full.
  - fifo_renable = rd_req & ~fifo_empty.
- Memory data timing:
  - Write data is captured by the memory at the same edge where fifo_wenable is high, at the current write_ptr.
  - Read data is valid combinationally in the same cycle fifo_renable is high, from the current read_ptr.
- Pointer update, registered:
  - An accepted write advances write_ptr by 1 on the next edge.
  - An accepted read advances read_ptr by 1 on the next edge.
  - Wrap-around: a pointer at OSTD_NUM-1 goes to 0. Do not rely on natural binary overflow.
- Count update, registered:
  - +1 on write only.
  - -1 on read only.
  - Unchanged when both are accepted or neither is.
- Simultaneous requests:
  - Not full and not empty: both accepted, count unchanged, both pointers advance.
  - Full: read accepted, write rejected (no write-through). Count goes to OSTD_NUM-1.
  - Empty: write accepted, read rejected (no bypass). Count goes to 1.
- Flags:
  - fifo_full, fifo_empty and below_thresh are combinational decodes of the registered fifo_count. Flags therefore update one cycle after the accepting edge.
- Errors:
  - overflow_err sets on the edge where wr_req=1 and fifo_full=1.
  - underflow_err sets on the edge where rd_req=1 and fifo_empty=1.
  - Both remain set until err_clr=1 at an edge, or reset.
  - If err_clr and a new error event occur on the same edge, the set wins.
  - A rejected request has no effect on pointers or count.
- Invariant: fifo_count equals (write_ptr - read_ptr) mod OSTD_NUM, with count == OSTD_NUM when the pointers are equal and the FIFO is full.

Test Plan:
- Defaults for all scenarios: OSTD_NUM=8, THRESHOLD_VALUE=4.
- Reset, then idle 3 cycles → ptrs=0, count=0, empty=1, full=0, below_thresh=1, errors=0, both enables=0.
- 8 consecutive wr_req → wenable high each cycle, write_ptr 0..7 then back to 0. Count reaches 8 and full=1 from the cycle after the 8th write. below_thresh drops to 0 once count=4.
- From full: wr_req for 1 cycle → wenable=0, ptrs and count unchanged, overflow_err=1 next cycle. Then err_clr pulse → overflow_err=0.
- From full, wr_req=rd_req=1 for 1 cycle → only renable=1, read_ptr=1, count=7, full=0.
- From empty: rd_req=1 → renable=0, underflow_err=1. Same cycle with wr_req=1 → write accepted, count=1.
- Write 5, then 20 cycles of simultaneous wr/rd → count stays 5, both pointers wrap past 7→0 at least twice, and the read index sequence trails the write index sequence by 5 mod 8.
- Write 6, assert areset_b=0 for one edge mid-stream → next cycle count=0, ptrs=0, empty=1. Any wr_req during the reset cycle is ignored.
